// File: rtl/apb_requester.sv
// APB initiator: takes one register command at a time, runs a SETUP/ACCESS
// transfer with wait-state timeout and alignment check, returns a response.
module apb_requester #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic [ADDR_W-1:0]     PADDR,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_W-1:0]     PWDATA,
    output logic [DATA_W/8-1:0]   PSTRB,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TO_LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [ADDR_W-1:0]  paddr_d;
    logic               psel_d, penable_d, pwrite_d;
    logic [DATA_W-1:0]  pwdata_d, rsp_rdata_d;
    logic [STRB_W-1:0]  pstrb_d;
    logic               rsp_valid_d, rsp_err_d, rsp_timeout_d;
    logic               cmd_ready_d, busy_d;
    logic               timeout_hit;

    // Last waited ACCESS cycle before abort; PREADY is checked first so it wins.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TO_LIM));

    // State and registered outputs; APB bus fields double as the command latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            PADDR       <= '0;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            PADDR       <= paddr_d;
            PSELx       <= psel_d;
            PENABLE     <= penable_d;
            PWRITE      <= pwrite_d;
            PWDATA      <= pwdata_d;
            PSTRB       <= pstrb_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
            cmd_ready   <= cmd_ready_d;
            busy        <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        paddr_d       = PADDR;
        pwrite_d      = PWRITE;
        pwdata_d      = PWDATA;
        pstrb_d       = PSTRB;
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_addr[1:0] != 2'b00) begin
                        state_d       = RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                    end else begin
                        state_d  = SETUP;
                        cnt_d    = '0;
                        psel_d   = 1'b1;
                        paddr_d  = cmd_addr;
                        pwrite_d = cmd_write;
                        pwdata_d = cmd_write ? cmd_wdata : '0;
                        pstrb_d  = cmd_write ? cmd_strb : '0;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                if (PREADY) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!PWRITE && !PSLVERR) ? PRDATA : '0;
                end else if (timeout_hit) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else if (cnt != {CNT_W{1'b1}}) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: stimulus pushes expected responses into a
// scoreboard queue, a monitor pops and compares on each response handshake.
module tb_apb_requester;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
        logic          to;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_err, rsp_timeout, busy;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] PADDR;
    logic          PSELx, PENABLE, PWRITE;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0, PSLVERR = 1'b0;

    rsp_t sb_q[$];
    int   n_vec = 0, n_fail = 0, n_pop = 0;
    int   ws = 0, acc_cnt = 0;
    logic hang = 1'b0;

    always #5 clk = ~clk;

    apb_requester #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Completer model: PREADY rises after ws wait states unless hang is set.
    always @(posedge clk) begin
        #1;
        if (PSELx && PENABLE) begin
            PREADY = !hang && (acc_cnt == ws);
            acc_cnt++;
        end else begin
            PREADY  = 1'b0;
            acc_cnt = 0;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        rsp_t e;
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rdata %0h err %0b, expected none", rsp_rdata, rsp_err);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                n_pop++;
            end
        end
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input rsp_t e);
        int t;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
        sb_q.push_back(e);
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: got cmd_ready 0, expected 1");
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int t = 0;
        while (!rsp_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!rsp_valid) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: got no rsp_valid, expected one within 100 cycles", name);
        end
    endtask

    // Counts ACCESS cycles from the SETUP negedge; returns at the first non-ACCESS negedge.
    task automatic count_access(input logic [AW-1:0] a, output int n, output logic stable);
        n = 0;
        stable = 1'b1;
        @(negedge clk);
        while (PENABLE && n < 100) begin
            if (PADDR !== a || PSELx !== 1'b1) stable = 1'b0;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int   n;
        logic st;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_psel", 64'(PSELx), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_paddr", 64'(PADDR), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

        // Zero-wait write, checking cycle-by-cycle latency
        ws = 0; PRDATA = 32'hDEAD_BEEF; PSLVERR = 1'b0;
        send(1'b1, 32'h8, 32'h1, 4'hF, '{32'h0, 1'b0, 1'b0});
        @(negedge clk);
        chk("wr_setup_psel", 64'(PSELx), 64'(1));
        chk("wr_setup_penable", 64'(PENABLE), 64'(0));
        chk("wr_setup_paddr", 64'(PADDR), 64'(32'h8));
        chk("wr_setup_pwrite", 64'(PWRITE), 64'(1));
        chk("wr_setup_pwdata", 64'(PWDATA), 64'(32'h1));
        chk("wr_setup_pstrb", 64'(PSTRB), 64'(4'hF));
        chk("wr_setup_cmd_ready", 64'(cmd_ready), 64'(0));
        @(negedge clk);
        chk("wr_access_penable", 64'(PENABLE), 64'(1));
        chk("wr_access_rsp_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        chk("wr_resp_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("wr_resp_psel", 64'(PSELx), 64'(0));

        // Read with 3 wait states
        ws = 3; PRDATA = 32'hA5A5_0003;
        send(1'b0, 32'hC, 32'hFFFF_FFFF, 4'hF, '{32'hA5A5_0003, 1'b0, 1'b0});
        @(negedge clk);
        chk("rd_setup_pstrb", 64'(PSTRB), 64'(0));
        chk("rd_setup_pwdata", 64'(PWDATA), 64'(0));
        count_access(32'hC, n, st);
        chk("rd_access_cycles", 64'(n), 64'(4));
        chk("rd_paddr_stable", 64'(st), 64'(1));
        chk("rd_resp_valid", 64'(rsp_valid), 64'(1));
        @(posedge clk);
        #1 rsp_ready = 1'b0;

        // Write with PSLVERR, response stalled; next command must wait
        ws = 0; PSLVERR = 1'b1; PRDATA = 32'h0;
        send(1'b1, 32'h14, 32'h55, 4'h3, '{32'h0, 1'b1, 1'b0});
        wait_rsp("slverr_rsp");
        @(posedge clk);
        #1 cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_cmd_ready", 64'(cmd_ready), 64'(0));
            chk("stall_rsp_valid", 64'(rsp_valid), 64'(1));
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0000_1234;
        send(1'b0, 32'h0, 32'h0, 4'h0, '{32'h0000_1234, 1'b0, 1'b0});
        wait_rsp("after_stall_rsp");

        // Timeout: completer never ready
        @(posedge clk);
        #1 hang = 1'b1; PRDATA = 32'hFFFF_FFFF;
        send(1'b0, 32'h20, 32'h0, 4'h0, '{32'h0, 1'b1, 1'b1});
        @(negedge clk);
        count_access(32'h20, n, st);
        chk("to_access_cycles", 64'(n), 64'(16));
        chk("to_psel_drop", 64'(PSELx), 64'(0));
        chk("to_rsp_valid", 64'(rsp_valid), 64'(1));
        @(posedge clk);
        #1 hang = 1'b0;

        // Misaligned address: immediate error, no bus activity
        send(1'b1, 32'h6, 32'h77, 4'hF, '{32'h0, 1'b1, 1'b0});
        @(negedge clk);
        chk("mis_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("mis_psel", 64'(PSELx), 64'(0));
        chk("mis_paddr_unchanged", 64'(PADDR), 64'(32'h20));

        // Reset during ACCESS
        @(posedge clk);
        #1 hang = 1'b1;
        send(1'b0, 32'h18, 32'h0, 4'h0, '{32'h0, 1'b0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_penable", 64'(PENABLE), 64'(1));
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_psel", 64'(PSELx), 64'(0));
        chk("mid_rst_penable", 64'(PENABLE), 64'(0));
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        sb_q.delete();
        @(posedge clk);
        #1 reset = 1'b0; hang = 1'b0; ws = 2; PRDATA = 32'hCAFE_0010; rsp_ready = 1'b0;
        send(1'b0, 32'h10, 32'h0, 4'h0, '{32'hCAFE_0010, 1'b0, 1'b0});
        wait_rsp("post_rst_rsp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 64'(rsp_valid), 64'(1));
            chk("hold_rsp_rdata", 64'(rsp_rdata), 64'(32'hCAFE_0010));
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("final_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        chk("rsp_count", 64'(n_pop), 64'(7));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB initiator: the requester end of the APB interface that the UART register block serves as completer.
- Accepts one register command at a time on a valid/ready command port and runs a full SETUP/ACCESS transfer.
- Returns read data and error status on a valid/ready response port.
- Sits between an on-chip controller (or bench driver) and APB completers such as the UART register block. Includes a wait-state timeout and an alignment check.

Parameters:
- ADDR_W, 32, PADDR and cmd_addr width.
- DATA_W, 32, PWDATA/PRDATA width; PSTRB width is DATA_W/8.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock (PCLK domain)
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  PSLVERR, timeout or misalignment
- rsp_timeout  out  1  transfer aborted by timeout
- busy  out  1  state != IDLE
- PADDR  out  ADDR_W  APB address
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PSTRB  out  DATA_W/8  APB strobes
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Reset (async, active-high):
  - state = IDLE, wait counter = 0.
  - All outputs 0, including PADDR, PWDATA, PSTRB, rsp_rdata. cmd_ready is 1 once reset is released.
  - Reset asserted mid-transfer drops PSELx/PENABLE immediately and discards the command and any pending response.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1. On cmd_valid, latch write/addr/wdata/strb.
  - If cmd_addr[1:0]!=0, go to RESP with rsp_err=1 and rsp_rdata=0; no bus activity.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - PSELx=1, PENABLE=0; PADDR/PWRITE/PWDATA driven from the latched command.
  - PSTRB = latched strb on writes, 0 on reads; PWDATA=0 on reads.
  - Next state is ACCESS.
- ACCESS:
  - PSELx=1, PENABLE=1; all other APB outputs held stable. Wait counter increments each cycle with PREADY=0.
  - On PREADY=1: capture PRDATA (reads only) and PSLVERR into rsp_err; go to RESP.
  - If counter reaches TIMEOUT_CYCLES with PREADY still 0 (TIMEOUT_CYCLES>0): go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - A PREADY arriving in the same cycle as the timeout threshold wins (normal completion).
- RESP:
  - PSELx=0, PENABLE=0; PADDR/PWRITE/PWDATA retain their last values.
  - rsp_valid=1 with rsp_* stable until rsp_ready. On rsp_valid&&rsp_ready, clear rsp_valid and return to IDLE. rsp_ready low stalls indefinitely.
  - cmd_ready=0 in SETUP, ACCESS and RESP; at most one outstanding command.
- Latency:
  - Accept at cycle N, SETUP at N+1, ACCESS at N+2.
  - Zero-wait completion gives rsp_valid at N+3.
  - Throughput is one transfer per 4 cycles with rsp_ready tied high.
- PSLVERR is sampled only when PREADY=1 in ACCESS and ignored otherwise. PRDATA is ignored on writes.
- Wait counter: width clog2(TIMEOUT_CYCLES+1), cleared on entry to SETUP, saturates and never wraps.

Test Plan:
- Write 0x8 data 0x1 strb 0xF, PREADY tied 1 -> SETUP at N+1 (PSELx=1, PENABLE=0), ACCESS at N+2, rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
- Read 0xC, completer inserts 3 wait states then returns PRDATA=0xA5A5_0003 -> PENABLE high 4 cycles with PADDR stable, PSTRB=0; rsp_rdata=0xA5A5_0003.
- Write 0x14 with PSLVERR=1 at PREADY -> rsp_err=1, rsp_timeout=0; next command accepted only after rsp_ready.
- TIMEOUT_CYCLES=16, PREADY held 0 -> abort after 16 ACCESS cycles, PSELx/PENABLE drop, rsp_err=1, rsp_timeout=1.
- cmd_addr=0x6 -> no PSELx pulse; rsp_valid next cycle with rsp_err=1.
- Reset asserted in ACCESS -> PSELx/PENABLE/rsp_valid 0 immediately; after release, read 0x10 completes normally; rsp_ready held 0 for 5 cycles keeps the response stable.
